// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes, default bit timing.
// Used by the TX serializer and intended for a future RX block.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int CLK_HZ            = 25_000_000;
  localparam int BAUD              = 115_200;
  localparam int CLKS_PER_BIT_DFLT = CLK_HZ / BAUD;

  // Even mode returns the XOR of the byte; odd mode returns its inverse.
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_stb pulses on the last cycle of every CLKS_PER_BIT window.
// Zero latency from clear; clear holds the count at zero so the next period is full length.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_stb
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign bit_stb = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || bit_stb) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: 8N/8O/8E with 1 or 2 stop bits, LSB first; start bit on the accept edge.
// Holds busy for the whole frame; upstream must wait for busy low before the next byte.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_ready,
  output logic       busy,
  output logic       tx,
  output logic       tx_done
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t r_state, w_state_nxt;
  logic [7:0]  r_shreg, w_shreg_nxt;
  logic [2:0]  r_bitcnt, w_bitcnt_nxt;
  logic        r_par, w_par_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_bit_stb;
  logic        w_baud_clr;

  // Timer idles at zero, so the start bit launched on the accept edge is a full period.
  assign w_baud_clr = (r_state == S_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_baud_clr),
    .bit_stb(w_bit_stb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_par    <= w_par_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_par_nxt    = r_par;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (data_ready) begin
          w_state_nxt  = S_START;
          w_shreg_nxt  = data;
          w_par_nxt    = parity_bit(data, PARITY);
          w_bitcnt_nxt = '0;
          w_tx_nxt     = 1'b0;
          w_busy_nxt   = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_stb) begin
          w_state_nxt  = S_DATA;
          w_bitcnt_nxt = '0;
          w_tx_nxt     = r_shreg[0];
        end
      end
      S_DATA: begin
        if (w_bit_stb) begin
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_nxt = '0;
            if (PARITY != PAR_NONE) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_tx_nxt     = r_shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_stb) begin
          w_state_nxt  = S_STOP;
          w_bitcnt_nxt = '0;
          w_tx_nxt     = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_stb) begin
          if (r_bitcnt == LAST_STOP) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy    = r_busy;
  assign tx      = r_tx;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: four serializer instances (8N1, 8O1, 8E1, 8N2) at 4 clocks per bit.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din [4];
  logic [3:0] dr;
  logic [3:0] tx_w, busy_w, done_w;

  int checks   = 0;
  int failures = 0;

  logic cap_tx   [128];
  logic cap_busy [128];
  logic cap_done [128];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .reset(reset), .data(din[0]), .data_ready(dr[0]),
    .busy(busy_w[0]), .tx(tx_w[0]), .tx_done(done_w[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .reset(reset), .data(din[1]), .data_ready(dr[1]),
    .busy(busy_w[1]), .tx(tx_w[1]), .tx_done(done_w[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clk(clk), .reset(reset), .data(din[2]), .data_ready(dr[2]),
    .busy(busy_w[2]), .tx(tx_w[2]), .tx_done(done_w[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .reset(reset), .data(din[3]), .data_ready(dr[3]),
    .busy(busy_w[3]), .tx(tx_w[3]), .tx_done(done_w[3]));

  // Sample k is taken on the falling edge after the k-th rising edge; k=0 is the accept edge.
  task automatic capture(input int idx, input int n, input int drop_k,
                         input int chg_k, input logic [7:0] chg_val, input int rst_k);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      cap_tx[k]   = tx_w[idx];
      cap_busy[k] = busy_w[idx];
      cap_done[k] = done_w[idx];
      if (k == drop_k) dr[idx] = 1'b0;
      if (k == chg_k) din[idx] = chg_val;
      if (k == rst_k) reset = 1'b1;
      else if (rst_k >= 0 && k == rst_k + 1) reset = 1'b0;
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dr    = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    idle_gap(3);
    checks++;
    if (tx_w !== 4'hF) begin failures++; $display("FAIL reset_tx got=%b exp=1111", tx_w); end
    checks++;
    if (busy_w !== 4'h0) begin failures++; $display("FAIL reset_busy got=%b exp=0000", busy_w); end
    checks++;
    if (done_w !== 4'h0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done_w); end
    reset = 1'b0;
    idle_gap(3);
    checks++;
    if (tx_w !== 4'hF || busy_w !== 4'h0) begin
      failures++;
      $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1111 busy=0000", tx_w, busy_w);
    end
  endtask

  task automatic test_basic();
    logic [11:0] fr;
    int bc, dn, dk;
    fr = {2'b11, 8'hA5, 1'b0};
    din[0] = 8'hA5; dr[0] = 1'b1;
    capture(0, 48, 0, -1, 8'h00, -1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (cap_tx[k] !== fr[k/4]) begin
        failures++; $display("FAIL basic_tx k=%0d got=%b exp=%b", k, cap_tx[k], fr[k/4]);
      end
    end
    bc = 0; dn = 0; dk = -1;
    for (int k = 0; k < 48; k++) begin
      if (cap_busy[k] === 1'b1) bc++;
      if (cap_done[k] === 1'b1) begin dn++; dk = k; end
    end
    checks++;
    if (bc != 40) begin failures++; $display("FAIL basic_busy_len got=%0d exp=40", bc); end
    checks++;
    if (dn != 1 || dk != 40) begin
      failures++; $display("FAIL basic_done pulses=%0d at=%0d exp 1 at 40", dn, dk);
    end
    checks++;
    if (cap_tx[40] !== 1'b1) begin failures++; $display("FAIL basic_idle_tx got=%b exp=1", cap_tx[40]); end
  endtask

  task automatic test_parity(input int idx, input logic par_exp, input string nm);
    logic [11:0] fr;
    int bc, dn, dk;
    fr = {1'b1, 1'b1, par_exp, 8'h07, 1'b0};
    idle_gap(2);
    din[idx] = 8'h07; dr[idx] = 1'b1;
    capture(idx, 50, 0, -1, 8'h00, -1);
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (cap_tx[k] !== fr[k/4]) begin
        failures++; $display("FAIL %s_tx k=%0d got=%b exp=%b", nm, k, cap_tx[k], fr[k/4]);
      end
    end
    bc = 0; dn = 0; dk = -1;
    for (int k = 0; k < 50; k++) begin
      if (cap_busy[k] === 1'b1) bc++;
      if (cap_done[k] === 1'b1) begin dn++; dk = k; end
    end
    checks++;
    if (bc != 44) begin failures++; $display("FAIL %s_busy_len got=%0d exp=44", nm, bc); end
    checks++;
    if (dn != 1 || dk != 44) begin
      failures++; $display("FAIL %s_done pulses=%0d at=%0d exp 1 at 44", nm, dn, dk);
    end
  endtask

  task automatic test_stop2();
    int bc, lo, dk;
    idle_gap(2);
    din[3] = 8'hFF; dr[3] = 1'b1;
    capture(3, 50, 0, -1, 8'h00, -1);
    lo = 0; bc = 0; dk = -1;
    for (int k = 0; k < 50; k++) begin
      if (cap_busy[k] === 1'b1) bc++;
      if (cap_done[k] === 1'b1) dk = k;
    end
    for (int k = 0; k < 44; k++) if (cap_tx[k] === 1'b0) lo++;
    checks++;
    if (cap_tx[0] !== 1'b0 || cap_tx[3] !== 1'b0 || lo != 4) begin
      failures++; $display("FAIL stop2_start low_cycles=%0d exp=4", lo);
    end
    checks++;
    if (cap_tx[4] !== 1'b1 || cap_tx[43] !== 1'b1) begin
      failures++; $display("FAIL stop2_high tx4=%b tx43=%b exp=1", cap_tx[4], cap_tx[43]);
    end
    checks++;
    if (bc != 44) begin failures++; $display("FAIL stop2_busy_len got=%0d exp=44", bc); end
    checks++;
    if (dk != 44) begin failures++; $display("FAIL stop2_done at=%0d exp=44", dk); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] f1, f2;
    int dn;
    f1 = {2'b11, 8'h00, 1'b0};
    f2 = {2'b11, 8'h01, 1'b0};
    idle_gap(2);
    din[0] = 8'h00; dr[0] = 1'b1;
    capture(0, 90, 41, 20, 8'h01, -1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (cap_tx[k] !== f1[k/4] || cap_busy[k] !== 1'b1) begin
        failures++; $display("FAIL b2b_f1 k=%0d tx=%b busy=%b exp tx=%b busy=1", k, cap_tx[k], cap_busy[k], f1[k/4]);
      end
    end
    checks++;
    if (cap_busy[40] !== 1'b0 || cap_tx[40] !== 1'b1 || cap_done[40] !== 1'b1) begin
      failures++; $display("FAIL b2b_gap busy=%b tx=%b done=%b exp 0/1/1", cap_busy[40], cap_tx[40], cap_done[40]);
    end
    for (int k = 41; k < 81; k++) begin
      checks++;
      if (cap_tx[k] !== f2[(k-41)/4] || cap_busy[k] !== 1'b1) begin
        failures++; $display("FAIL b2b_f2 k=%0d tx=%b busy=%b exp tx=%b busy=1", k, cap_tx[k], cap_busy[k], f2[(k-41)/4]);
      end
    end
    dn = 0;
    for (int k = 0; k < 90; k++) if (cap_done[k] === 1'b1) dn++;
    checks++;
    if (cap_done[81] !== 1'b1 || dn != 2) begin
      failures++; $display("FAIL b2b_done done81=%b pulses=%0d exp 1 and 2", cap_done[81], dn);
    end
    checks++;
    if (cap_busy[85] !== 1'b0 || cap_tx[85] !== 1'b1) begin
      failures++; $display("FAIL b2b_after busy=%b tx=%b exp 0/1", cap_busy[85], cap_tx[85]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] fr, fr2;
    int dn, bc;
    fr  = {2'b11, 8'h96, 1'b0};
    fr2 = {2'b11, 8'h5A, 1'b0};
    idle_gap(2);
    din[0] = 8'h96; dr[0] = 1'b1;
    capture(0, 19, 0, -1, 8'h00, 16);
    for (int k = 0; k < 17; k++) begin
      checks++;
      if (cap_tx[k] !== fr[k/4]) begin
        failures++; $display("FAIL rst_pre_tx k=%0d got=%b exp=%b", k, cap_tx[k], fr[k/4]);
      end
    end
    checks++;
    if (cap_tx[17] !== 1'b1 || cap_busy[17] !== 1'b0) begin
      failures++; $display("FAIL rst_mid tx=%b busy=%b exp tx=1 busy=0", cap_tx[17], cap_busy[17]);
    end
    dn = 0;
    for (int k = 0; k < 19; k++) if (cap_done[k] === 1'b1) dn++;
    checks++;
    if (dn != 0) begin failures++; $display("FAIL rst_no_done pulses=%0d exp=0", dn); end
    din[0] = 8'h5A; dr[0] = 1'b1;
    capture(0, 48, 0, -1, 8'h00, -1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (cap_tx[k] !== fr2[k/4]) begin
        failures++; $display("FAIL rst_post_tx k=%0d got=%b exp=%b", k, cap_tx[k], fr2[k/4]);
      end
    end
    bc = 0;
    for (int k = 0; k < 48; k++) if (cap_busy[k] === 1'b1) bc++;
    checks++;
    if (bc != 40 || cap_done[40] !== 1'b1) begin
      failures++; $display("FAIL rst_post_frame busy_len=%0d done40=%b exp 40 and 1", bc, cap_done[40]);
    end
  endtask

  task automatic test_data_change();
    logic [11:0] fr;
    fr = {2'b11, 8'h3C, 1'b0};
    idle_gap(2);
    din[0] = 8'h3C; dr[0] = 1'b1;
    capture(0, 44, 0, 10, 8'hC3, -1);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (cap_tx[k] !== fr[k/4]) begin
        failures++; $display("FAIL datachg_tx k=%0d got=%b exp=%b", k, cap_tx[k], fr[k/4]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    dr    = 4'h0;
    test_reset();
    test_basic();
    test_parity(2, 1'b1, "par_even");
    test_parity(1, 1'b0, "par_odd");
    test_stop2();
    test_back_to_back();
    test_reset_midframe();
    test_data_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
